// File: rtl/fp32_operand_prep.sv
// rtl/fp32_operand_prep.sv - binary32 operand classifier and denormal normalizer for the sqrt stage
// Optional feature macro: FP_PREP_FTZ_EN (flush denormals to zero in a single cycle)

module fp32_operand_prep #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [9:0]  out_exp,
  output logic [23:0] out_mant,
  output logic [1:0]  out_class,
  output logic        out_denorm
);

  typedef enum logic {IDLE, NORM} state_t;

  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_FIN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  state_t      state, state_next;
  logic        work_sign;
  logic [9:0]  work_exp;
  logic [23:0] work_mant;

  logic [7:0]  in_e;
  logic [22:0] in_m;
  logic        is_denorm;
  logic        out_free;
  logic        in_fire;
  logic        accept_load;
  logic        start_norm;

  logic [4:0]  sh_amt;
  logic [23:0] shifted_mant;
  logic [9:0]  shifted_exp;
  logic        norm_done;
  logic        norm_write;
  logic        norm_stall;

  logic [9:0]  cls_exp;
  logic [23:0] cls_mant;
  logic [1:0]  cls_class;
  logic        cls_denorm;

  assign in_e      = in_data[30:23];
  assign in_m      = in_data[22:0];
  assign is_denorm = (in_e == 8'd0) && (in_m != 23'd0);
  assign out_free  = !out_valid || out_ready;
  assign in_ready  = !rst && (state == IDLE) && out_free;
  assign in_fire   = in_valid && in_ready;

`ifdef FP_PREP_FTZ_EN
  assign accept_load = in_fire;
  assign start_norm  = 1'b0;
`else
  assign accept_load = in_fire && !is_denorm;
  assign start_norm  = in_fire && is_denorm;
`endif

  // One normalization step: a wide shift only when it cannot push the leading one past bit 23
  always_comb begin
    sh_amt       = (work_mant[23 -: SHIFT_STEP] == '0) ? 5'(SHIFT_STEP) : 5'd1;
    shifted_mant = work_mant << sh_amt;
    shifted_exp  = work_exp - {5'b0, sh_amt};
  end

  assign norm_done  = (state == NORM) && shifted_mant[23];
  assign norm_write = norm_done && out_free;
  assign norm_stall = norm_done && !out_free;

  // Classify the incoming operand for the single-cycle load path
  always_comb begin
    cls_exp    = 10'd0;
    cls_mant   = 24'd0;
    cls_class  = CLS_ZERO;
    cls_denorm = 1'b0;
    if (in_e == 8'hFF) begin
      if (in_m == 23'd0) begin
        cls_class = CLS_INF;
      end else begin
        cls_class = CLS_NAN;
        cls_mant  = {1'b1, in_m};
      end
    end else if (in_e == 8'd0) begin
      cls_class  = CLS_ZERO;
      cls_denorm = is_denorm;
    end else begin
      cls_class = CLS_FIN;
      cls_exp   = {2'b00, in_e} - 10'd127;
      cls_mant  = {1'b1, in_m};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: leave NORM only once the result has landed in the output register
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_norm) state_next = NORM;
      NORM:    if (norm_write) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Work register: load the denormal, then shift until normalized; hold while the output is blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      work_sign <= 1'b0;
      work_exp  <= 10'd0;
      work_mant <= 24'd0;
    end else if (start_norm) begin
      work_sign <= in_data[31];
      work_exp  <= -10'sd126;
      work_mant <= {1'b0, in_m};
    end else if ((state == NORM) && !norm_stall) begin
      work_exp  <= shifted_exp;
      work_mant <= shifted_mant;
    end
  end

  // Output register: accept path or normalizer completion, otherwise drain on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_exp    <= 10'd0;
      out_mant   <= 24'd0;
      out_class  <= CLS_ZERO;
      out_denorm <= 1'b0;
    end else if (accept_load) begin
      out_valid  <= 1'b1;
      out_sign   <= in_data[31];
      out_exp    <= cls_exp;
      out_mant   <= cls_mant;
      out_class  <= cls_class;
      out_denorm <= cls_denorm;
    end else if (norm_write) begin
      out_valid  <= 1'b1;
      out_sign   <= work_sign;
      out_exp    <= shifted_exp;
      out_mant   <= shifted_mant;
      out_class  <= CLS_FIN;
      out_denorm <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp32_operand_prep.sv
// tb/tb_fp32_operand_prep.sv - directed self-checking bench for fp32_operand_prep

module tb_fp32_operand_prep;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_mant;
  logic [1:0]  out_class;
  logic        out_denorm;

  int checks = 0;
  int errors = 0;

  fp32_operand_prep #(.SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_class(out_class), .out_denorm(out_denorm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Compare the whole output bundle {valid, sign, exp, mant, class, denorm}
  task automatic chk_out(input string tag, input logic v, input logic s, input logic [9:0] e,
                         input logic [23:0] m, input logic [1:0] c, input logic d);
    chk(tag, {25'd0, out_valid, out_sign, out_exp, out_mant, out_class, out_denorm},
             {25'd0, v, s, e, m, c, d});
  endtask

  // Present one operand for exactly one cycle; the caller has ensured in_ready
  task automatic send(input string tag, input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 32'd0;
  endtask

  logic [31:0] hs_data [4];
  logic [9:0]  hs_exp  [4];
  logic [23:0] hs_mant [4];
  int          waited;

  initial begin
    hs_data = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    hs_exp  = '{10'd0, 10'd1, 10'd1, 10'd2};
    hs_mant = '{24'h800000, 24'h800000, 24'hC00000, 24'h800000};

    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk_out("rst_state", 1'b0, 1'b0, 10'd0, 24'd0, 2'd0, 1'b0);

    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Normal operand, 1-cycle latency
    send("normal", 32'h40800000);
    chk_out("normal_out", 1'b1, 1'b0, 10'd2, 24'h800000, 2'd1, 1'b0);

    // Specials
    send("nan", 32'h7F800001);
    chk_out("nan_out", 1'b1, 1'b0, 10'd0, 24'h800001, 2'd3, 1'b0);
    send("neg_inf", 32'hFF800000);
    chk_out("neg_inf_out", 1'b1, 1'b1, 10'd0, 24'd0, 2'd2, 1'b0);
    send("neg_zero", 32'h80000000);
    chk_out("neg_zero_out", 1'b1, 1'b1, 10'd0, 24'd0, 2'd0, 1'b0);

    // Largest-exponent denormal
    send("dn_big", 32'h00400000);
`ifdef FP_PREP_FTZ_EN
    chk_out("dn_big_ftz", 1'b1, 1'b0, 10'd0, 24'd0, 2'd0, 1'b1);
    tick();
`else
    chk("dn_big_busy", {63'd0, in_ready}, 64'd0);
    chk("dn_big_pending", {63'd0, out_valid}, 64'd0);
    tick();
    chk_out("dn_big_out", 1'b1, 1'b0, 10'h381, 24'h800000, 2'd1, 1'b1);
    tick();
`endif

    // Smallest denormal: 23 normalization cycles after acceptance
    send("dn_min", 32'h00000001);
`ifdef FP_PREP_FTZ_EN
    chk_out("dn_min_ftz", 1'b1, 1'b0, 10'd0, 24'd0, 2'd0, 1'b1);
    tick();
`else
    waited = 0;
    while (!out_valid && waited < 40) begin
      tick();
      waited++;
    end
    chk("dn_min_latency", 64'(waited), 64'd23);
    chk_out("dn_min_out", 1'b1, 1'b0, 10'h36B, 24'h800000, 2'd1, 1'b1);
    tick();
`endif
    chk("drained", {63'd0, out_valid}, 64'd0);

    // Back-to-back normals at full throughput
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = hs_data[i];
      #1;
      chk($sformatf("b2b_in_ready_%0d", i), {63'd0, in_ready}, 64'd1);
      tick();
      chk_out($sformatf("b2b_out_%0d", i), 1'b1, 1'b0, hs_exp[i], hs_mant[i], 2'd1, 1'b0);
    end

    // Stall: a fifth operand waits while the fourth result is held
    in_data   = 32'hC0A00000;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
      tick();
      chk_out($sformatf("stall_hold_%0d", i), 1'b1, 1'b0, 10'd2, 24'h800000, 2'd1, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 32'd0;
    chk_out("release_out", 1'b1, 1'b1, 10'd2, 24'hA00000, 2'd1, 1'b0);
    tick();
    chk("release_no_dup", {63'd0, out_valid}, 64'd0);

    // Reset during the fifth normalization cycle
    send("rst_mid", 32'h00000001);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_mid_idle", {63'd0, in_ready}, 64'd1);
    send("after_rst", 32'h3F800000);
    chk_out("after_rst_out", 1'b1, 1'b0, 10'd0, 24'h800000, 2'd1, 1'b0);
    for (int i = 0; i < 25; i++) tick();
    chk("after_rst_quiet", {63'd0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_operand_prep.md
# fp32_operand_prep

Upstream operand front-end for the single-precision square-root stage. Accepts raw IEEE-754 binary32 words over a valid/ready handshake and classifies each operand. Denormals are normalized by an iterative multi-cycle left shift. Each result is presented as sign, unbiased signed exponent and 24-bit mantissa with explicit leading one, so the sqrt stage never sees an unnormalized significand.

## Interface
Parameters:
- SHIFT_STEP, 1 — maximum left-shift bits per normalization cycle; legal values 1, 2, 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  32  raw binary32 operand.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_sign  output  1  operand sign, passed through for every class.
- out_exp  output  10  signed two's-complement unbiased exponent, range -149..+127.
- out_mant  output  24  normalized significand; bit 23 = 1 for finite non-zero.
- out_class  output  2  operand class: 0 zero, 1 finite, 2 inf, 3 NaN.
- out_denorm  output  1  operand was denormal.

## Operation
- FSM states: IDLE and NORM.
- IDLE:
  - in_ready = !rst && (!out_valid || out_ready).
  - On accept, the operand is classified.
- Non-denormal accept: output register is written the same edge; state stays IDLE.
  - Zero: class 0, exp 0, mant 0.
  - Inf: class 2, exp 0, mant 0.
  - NaN: class 3, exp 0, mant = {1'b1, in_data[22:0]}.
  - Finite normal: class 1, exp = E-127, mant = {1'b1, M}.
- Denormal accept (E=0, M≠0): work register loads mant={1'b0,M} and exp=-126; state goes to NORM.
- NORM, each cycle:
  - Shift by SHIFT_STEP if work_mant[23:24-SHIFT_STEP]==0, else shift by 1.
  - exp decrements by the same amount.
  - When the shifted mantissa has bit 23 set, the result is written to the output register with class 1 and out_denorm=1; state returns to IDLE.
- Back-pressure in NORM: if the final shift would complete while out_valid=1 and out_ready=0, the work register holds unshifted and state stays NORM until the output frees. The result is never overwritten.
- Output register: cleared (out_valid←0) on out_valid && out_ready unless reloaded the same edge. Fields are stable while out_valid && !out_ready.
- in_ready = 0 throughout NORM.
- Arithmetic: exp is 10-bit signed. Minimum -149 occurs for M=0x000001; no exponent overflow is possible.

## Timing
- Reset values: out_valid 0, out_sign 0, out_exp 0, out_mant 0, out_class 0, out_denorm 0, state IDLE.
- in_ready is 0 while rst=1.
- Normal, zero, inf and NaN operands: accept in cycle T, out_valid visible in cycle T+1.
- Full throughput of one per cycle when out_ready is held high.
- Denormal needing k shifts at SHIFT_STEP=1 (k = leading zeros of the 24-bit {0,M}, 1..23): out_valid visible in cycle T+1+k, absent back-pressure.
- Simultaneous drain and accept: allowed in IDLE. The output register takes the new result; out_valid stays 1.
- Reset mid-NORM: the next edge returns to IDLE, discards the work register and clears out_valid.

## Configuration
- FP_PREP_FTZ_EN defined:
  - Denormal operands are flushed to zero: class 0, exp 0, mant 0, sign preserved, out_denorm=1.
  - Single-cycle latency; state NORM is never entered.
- Undefined: denormals are normalized as in Operation.

## Test plan
- Normal operand: 0x40800000 accepted at T → cycle T+1: sign 0, exp +2, mant 0x800000, class 1, denorm 0.
- Smallest denormal: 0x00000001, SHIFT_STEP=1 → out_valid at T+24, exp -149, mant 0x800000, class 1, denorm 1.
  - With FP_PREP_FTZ_EN: class 0, mant 0 at T+1.
- Largest-exponent denormal: 0x00400000 → out_valid at T+2, exp -127, mant 0x800000.
  - in_ready = 0 in cycle T+1.
- Specials:
  - 0x7F800001 → class 3, mant 0x800001.
  - 0xFF800000 → class 2, sign 1.
  - 0x80000000 → class 0, sign 1.
  - Each with 1-cycle latency.
- Handshake: four back-to-back normals with out_ready=1 → four results on consecutive cycles. Then out_ready=0 for 3 cycles → out_* stable, in_ready 0, no loss or duplication after release.
- Reset mid-op: rst pulsed during the 5th NORM cycle of 0x00000001 → next cycle out_valid 0, state IDLE. After release, 0x3F800000 yields exp 0, mant 0x800000 at T+1.
